// File: rtl/usb_frame_packer.sv
// usb_frame_packer: output stage of the BLE analyzer.
// Captures one decoded packet into a local buffer, tagging it with the RSSI
// and channel present at its first byte. It then emits a USB frame made of
// three header bytes (RSSI, channel, length) followed by the payload.
// Packets that cannot be taken are dropped and counted in a saturating counter.
module usb_frame_packer #(
    parameter int DATA_W    = 8,
    parameter int CHANNEL_W = 7,
    parameter int RSSI_W    = 8,
    parameter int MAX_BYTES = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DATA_W-1:0]    pkt_data_i,
    input  logic                 pkt_valid_i,
    input  logic                 pkt_sop_i,
    input  logic                 pkt_eop_i,
    input  logic                 pkt_abort_i,
    input  logic [CHANNEL_W-1:0] channel_i,
    input  logic [RSSI_W-1:0]    rssi_i,
    output logic [DATA_W-1:0]    data_o,
    output logic                 valid_o,
    output logic                 frame_o,
    output logic [7:0]           drop_cnt_o
);

    // Buffer addressing; one address bit minimum, so a 1-byte buffer still elaborates
    localparam int          ADDR_W  = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam logic [7:0]  MAX_CNT = 8'(MAX_BYTES);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        CAPTURE      = 3'd1,
        SEND_RSSI    = 3'd2,
        SEND_CHAN    = 3'd3,
        SEND_LEN     = 3'd4,
        SEND_PAYLOAD = 3'd5
    } state_t;

    state_t                 state_r;
    logic [DATA_W-1:0]      buf_r [MAX_BYTES];
    logic [7:0]             cnt_r;
    logic [7:0]             rd_idx_r;
    logic [RSSI_W-1:0]      rssi_r;
    logic [CHANNEL_W-1:0]   chan_r;

    logic                   sop_s;
    logic                   wr_en_s;
    logic [ADDR_W-1:0]      wr_addr_s;

    // Saturating increment for the drop counter: it sticks at 255
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'hFF) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

    assign sop_s = pkt_valid_i & pkt_sop_i;

    // Buffer write decode: mirrors the capture rules applied in the FSM
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = {ADDR_W{1'b0}};
        case (state_r)
            IDLE: begin
                if (sop_s) begin
                    wr_en_s = 1'b1;
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            CAPTURE: begin
                if (pkt_abort_i) begin
                    wr_en_s = 1'b0;
                end else if (sop_s) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = {ADDR_W{1'b0}};
                end else if (pkt_valid_i && (cnt_r < MAX_CNT)) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = cnt_r[ADDR_W-1:0];
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            default: begin
                wr_en_s = 1'b0;
            end
        endcase
    end

    // Packet byte storage; contents need no reset because cnt_r gates their use
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            buf_r[wr_addr_s] <= pkt_data_i;
        end
    end

    // Main FSM: capture, frame emission with registered outputs, drop counting
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r    <= IDLE;
            cnt_r      <= 8'd0;
            rd_idx_r   <= 8'd0;
            rssi_r     <= {RSSI_W{1'b0}};
            chan_r     <= {CHANNEL_W{1'b0}};
            data_o     <= {DATA_W{1'b0}};
            valid_o    <= 1'b0;
            frame_o    <= 1'b0;
            drop_cnt_o <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    data_o  <= {DATA_W{1'b0}};
                    valid_o <= 1'b0;
                    frame_o <= 1'b0;
                    if (sop_s) begin
                        rssi_r <= rssi_i;
                        chan_r <= channel_i;
                        cnt_r  <= 8'd1;
                        if (pkt_eop_i) begin
                            // Single-byte packet: header uses the live RSSI being latched now
                            state_r <= SEND_RSSI;
                            data_o  <= DATA_W'(rssi_i);
                            valid_o <= 1'b1;
                            frame_o <= 1'b1;
                        end else begin
                            state_r <= CAPTURE;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CAPTURE: begin
                    if (pkt_abort_i) begin
                        // Abandoned by the decoder: silent discard, not a drop
                        state_r <= IDLE;
                        cnt_r   <= 8'd0;
                    end else if (sop_s) begin
                        // New packet before eop: old one is dropped, restart with this byte
                        drop_cnt_o <= sat_inc(drop_cnt_o);
                        rssi_r     <= rssi_i;
                        chan_r     <= channel_i;
                        cnt_r      <= 8'd1;
                        if (pkt_eop_i) begin
                            state_r <= SEND_RSSI;
                            data_o  <= DATA_W'(rssi_i);
                            valid_o <= 1'b1;
                            frame_o <= 1'b1;
                        end else begin
                            state_r <= CAPTURE;
                        end
                    end else if (pkt_valid_i) begin
                        if (cnt_r == MAX_CNT) begin
                            // Buffer full: drop and ignore the rest until the next sop
                            drop_cnt_o <= sat_inc(drop_cnt_o);
                            state_r    <= IDLE;
                            cnt_r      <= 8'd0;
                        end else begin
                            cnt_r <= cnt_r + 8'd1;
                            if (pkt_eop_i) begin
                                state_r <= SEND_RSSI;
                                data_o  <= DATA_W'(rssi_r);
                                valid_o <= 1'b1;
                                frame_o <= 1'b1;
                            end else begin
                                state_r <= CAPTURE;
                            end
                        end
                    end else begin
                        state_r <= CAPTURE;
                    end
                end
                SEND_RSSI: begin
                    if (sop_s) begin
                        drop_cnt_o <= sat_inc(drop_cnt_o);
                    end
                    state_r <= SEND_CHAN;
                    data_o  <= DATA_W'(chan_r);
                end
                SEND_CHAN: begin
                    if (sop_s) begin
                        drop_cnt_o <= sat_inc(drop_cnt_o);
                    end
                    state_r <= SEND_LEN;
                    data_o  <= DATA_W'(cnt_r);
                end
                SEND_LEN: begin
                    if (sop_s) begin
                        drop_cnt_o <= sat_inc(drop_cnt_o);
                    end
                    state_r  <= SEND_PAYLOAD;
                    data_o   <= buf_r[{ADDR_W{1'b0}}];
                    rd_idx_r <= 8'd1;
                end
                SEND_PAYLOAD: begin
                    if (sop_s) begin
                        drop_cnt_o <= sat_inc(drop_cnt_o);
                    end
                    if (rd_idx_r == cnt_r) begin
                        // Last payload byte already on the bus: close the frame
                        state_r  <= IDLE;
                        data_o   <= {DATA_W{1'b0}};
                        valid_o  <= 1'b0;
                        frame_o  <= 1'b0;
                        cnt_r    <= 8'd0;
                        rd_idx_r <= 8'd0;
                    end else begin
                        data_o   <= buf_r[rd_idx_r[ADDR_W-1:0]];
                        rd_idx_r <= rd_idx_r + 8'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    data_o  <= {DATA_W{1'b0}};
                    valid_o <= 1'b0;
                    frame_o <= 1'b0;
                    cnt_r   <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/usb_frame_packer.md
Name: usb_frame_packer

Overview:
- Output stage of the BLE analyzer; sits directly downstream of the packet decoder, upstream of the USB FIFO.
- Buffers one decoded BLE packet (byte stream with start/end markers) and tags it with the RSSI and channel sampled at packet start.
- Emits the packet as one USB frame on data_o/valid_o/frame_o: header bytes (RSSI, channel, length) followed by the payload.
- Packets that cannot be accepted are dropped and counted.

Parameters:
- DATA_W, 8, width of pkt_data_i and data_o (equals DATA_O_SIZE)
- CHANNEL_W, 7, width of channel_i (equals CHANNEL_FIELD_SIZE)
- RSSI_W, 8, width of rssi_i (equals RSSI_FIELD_SIZE); must be <= DATA_W
- MAX_BYTES, 64, packet buffer depth in bytes; legal range 1..255

Ports:
- clk_i  in  1  system clock; all logic on rising edge
- rst_i  in  1  reset; asynchronous, active-low
- pkt_data_i  in  DATA_W  decoded packet byte
- pkt_valid_i  in  1  pkt_data_i valid this cycle
- pkt_sop_i  in  1  first byte of packet; qualified by pkt_valid_i
- pkt_eop_i  in  1  last byte of packet; qualified by pkt_valid_i
- pkt_abort_i  in  1  decoder abandons the current packet, e.g. CRC fail
- channel_i  in  CHANNEL_W  channel of the current packet
- rssi_i  in  RSSI_W  RSSI of the current packet
- data_o  out  DATA_W  USB frame byte
- valid_o  out  1  data_o valid
- frame_o  out  1  high for every byte of a frame
- drop_cnt_o  out  8  dropped-packet count, saturates at 255

Behaviour:
- Reset (rst_i=0, async): state IDLE; data_o=0, valid_o=0, frame_o=0, drop_cnt_o=0; buffer count=0. Reset mid-frame forces outputs low at once; the frame is lost and not counted.
- FSM states: IDLE, CAPTURE, SEND_RSSI, SEND_CHAN, SEND_LEN, SEND_PAYLOAD.
- IDLE:
  - pkt_valid_i without pkt_sop_i is ignored.
  - pkt_valid_i with pkt_sop_i stores the byte at index 0 and latches rssi_i and channel_i that cycle.
  - If pkt_eop_i is also set, the packet is 1 byte and the next state is SEND_RSSI; otherwise the next state is CAPTURE.
- CAPTURE:
  - Each pkt_valid_i byte is written at the next index.
  - A byte with pkt_eop_i is stored; count becomes N and the next state is SEND_RSSI.
  - A byte with pkt_sop_i drops the current packet (drop_cnt+1) and restarts capture with this byte, re-latching rssi_i and channel_i.
  - A byte that would make the count exceed MAX_BYTES drops the packet (drop_cnt+1) and returns to IDLE; the remaining bytes are ignored until the next sop.
  - pkt_abort_i discards the packet without counting it; next state IDLE. It has priority over a same-cycle byte.
- pkt_abort_i in any other state: ignored.
- Send sequence, with the eop byte accepted at cycle t:
  - t+1 SEND_RSSI: data_o = latched RSSI, zero-extended.
  - t+2 SEND_CHAN: data_o = latched channel, zero-extended.
  - t+3 SEND_LEN: data_o = N.
  - t+4 .. t+3+N SEND_PAYLOAD: bytes 0..N-1 in order.
  - valid_o=1 and frame_o=1 on all N+3 cycles.
  - Cycle t+4+N: IDLE; valid_o=0, frame_o=0, data_o=0.
- Input during SEND_*: all bytes are discarded. Each pkt_sop_i seen adds 1 to drop_cnt; continuation bytes are not counted.
- Frame spacing: frame_o is low for at least 1 cycle between frames, because capture takes at least 1 cycle.
- All outputs are registered. Whenever valid_o=0, data_o=0.
- drop_cnt_o holds at 255 and never wraps.

Test Plan:
- Basic packet: sop with rssi_i=0xC3, channel_i=37, bytes 0x11,0x22,0x33 (eop on the last) -> output exactly C3,25,03,11,22,33 on 6 consecutive cycles starting the cycle after eop; frame_o high on those 6 cycles only; drop_cnt_o=0.
- 1-byte packet: sop+eop same cycle, byte 0xAB, rssi 0x10, channel 0 -> frame 10,00,01,AB.
- Overflow: MAX_BYTES=64, send 65 bytes without eop -> no frame, drop_cnt_o=1. The next legal 2-byte packet frames normally with length 02.
- Busy drop: start a second sop 2 cycles after eop of a 40-byte packet -> first frame intact (43 bytes); drop_cnt_o=1; a sop issued the cycle after frame_o falls is accepted.
- Restart and abort:
  - sop, 5 bytes, sop again + 2 bytes + eop -> frame length 02 carrying the second packet's rssi/channel; drop_cnt_o=1.
  - sop, 3 bytes, abort -> no frame; drop_cnt_o unchanged.
- Reset mid-frame: assert rst_i low during payload byte 10 -> outputs go 0 asynchronously, drop_cnt_o=0. After release the FSM is IDLE, and a new packet frames correctly.
